// File: rtl/bridge_io.sv
// CPU bus bridge: address decode to DRAM / 7-seg / LED / switch / timer registers.
// Latency: reads are combinational (zero wait state); register writes land on the next cpu_clk edge.
// Backpressure: none; the bus is never stalled and every access completes in its own cycle.
//
// Ports:
//   cpu_clk, cpu_rst (async, active-low)       clock and reset
//   Bus_addr/Bus_we/Bus_wdata -> Bus_rdata     CPU side, combinational read data
//   dram_addr/dram_we/dram_wdata <- dram_rdata DRAM side (word address = Bus_addr[15:2])
//   sw -> (2-flop sync) ; led ; dig_en/seg     board I/O, dig_en and seg active-low
// Build option: define BRIDGE_TIMER_EN to include the free-running TIMER register and its prescaler.
module bridge_io #(
    parameter int SCAN_DIV  = 20000,
    parameter int TIMER_DIV = 100
) (
    input  logic        cpu_clk,
    input  logic        cpu_rst,
    input  logic [31:0] Bus_addr,
    input  logic        Bus_we,
    input  logic [31:0] Bus_wdata,
    output logic [31:0] Bus_rdata,
    output logic [13:0] dram_addr,
    output logic        dram_we,
    output logic [31:0] dram_wdata,
    input  logic [31:0] dram_rdata,
    input  logic [23:0] sw,
    output logic [23:0] led,
    output logic [7:0]  dig_en,
    output logic [7:0]  seg
);

    localparam logic [31:0] ADDR_DIG   = 32'hFFFF_F000;
    localparam logic [31:0] ADDR_TIMER = 32'hFFFF_F020;
    localparam logic [31:0] ADDR_LED   = 32'hFFFF_F060;
    localparam logic [31:0] ADDR_SW    = 32'hFFFF_F070;

    localparam int SCW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [SCW-1:0] SCAN_MAX = SCW'(SCAN_DIV - 1);

    // ------------------------------------------------------------------
    // Address decode
    // ------------------------------------------------------------------
    logic sel_dig, sel_timer, sel_led, sel_sw, sel_dram;

    always_comb begin
        sel_dig   = (Bus_addr == ADDR_DIG);
        sel_timer = (Bus_addr == ADDR_TIMER);
        sel_led   = (Bus_addr == ADDR_LED);
        sel_sw    = (Bus_addr == ADDR_SW);
        // TIMER is decoded even when the timer is not built, so it never falls through to DRAM.
        sel_dram  = !(sel_dig || sel_timer || sel_led || sel_sw);
    end

    logic wr_dig, wr_led, wr_timer;
    assign wr_dig   = Bus_we && sel_dig;
    assign wr_led   = Bus_we && sel_led;
    assign wr_timer = Bus_we && sel_timer;

    assign dram_addr  = Bus_addr[15:2];
    assign dram_wdata = Bus_wdata;
    assign dram_we    = Bus_we && sel_dram;

    // ------------------------------------------------------------------
    // Switch synchronizer
    // ------------------------------------------------------------------
    logic [23:0] sw_meta, sw_sync;

    always_ff @(posedge cpu_clk or negedge cpu_rst) begin
        if (!cpu_rst) begin
            sw_meta <= '0;
            sw_sync <= '0;
        end else begin
            sw_meta <= sw;
            sw_sync <= sw_meta;
        end
    end

    // ------------------------------------------------------------------
    // LED register
    // ------------------------------------------------------------------
    logic [23:0] led_q;

    always_ff @(posedge cpu_clk or negedge cpu_rst) begin
        if (!cpu_rst) begin
            led_q <= '0;
        end else if (wr_led) begin
            led_q <= Bus_wdata[23:0];
        end
    end

    assign led = led_q;

    // ------------------------------------------------------------------
    // Timer (optional)
    // ------------------------------------------------------------------
    logic [31:0] timer_val;

`ifdef BRIDGE_TIMER_EN
    localparam int TW = (TIMER_DIV > 1) ? $clog2(TIMER_DIV) : 1;
    localparam logic [TW-1:0] PRE_MAX = TW'(TIMER_DIV - 1);

    logic [TW-1:0] pre_q;
    logic [31:0]   timer_q;

    // A CPU write takes priority over a coincident tick and restarts the prescale period.
    always_ff @(posedge cpu_clk or negedge cpu_rst) begin
        if (!cpu_rst) begin
            pre_q   <= '0;
            timer_q <= '0;
        end else if (wr_timer) begin
            pre_q   <= '0;
            timer_q <= Bus_wdata;
        end else if (pre_q == PRE_MAX) begin
            pre_q   <= '0;
            timer_q <= timer_q + 32'd1;
        end else begin
            pre_q   <= pre_q + 1'b1;
        end
    end

    assign timer_val = timer_q;
`else
    // Without the timer the register reads as zero and writes are dropped.
    logic unused_timer_cfg;
    assign unused_timer_cfg = (TIMER_DIV < 1) || wr_timer;
    assign timer_val        = '0;
`endif

    // ------------------------------------------------------------------
    // 7-segment display
    // ------------------------------------------------------------------
    logic [31:0]    dig_q, dig_nxt;
    logic [SCW-1:0] scan_q;
    logic [2:0]     idx_q, idx_nxt;
    logic           scan_wrap;
    logic [7:0]     dig_en_q, seg_q;

    function automatic logic [7:0] glyph(input logic [3:0] nib);
        logic [7:0] g;
        case (nib)
            4'h0: g = 8'hC0;
            4'h1: g = 8'hF9;
            4'h2: g = 8'hA4;
            4'h3: g = 8'hB0;
            4'h4: g = 8'h99;
            4'h5: g = 8'h92;
            4'h6: g = 8'h82;
            4'h7: g = 8'hF8;
            4'h8: g = 8'h80;
            4'h9: g = 8'h90;
            4'hA: g = 8'h88;
            4'hB: g = 8'h83;
            4'hC: g = 8'hC6;
            4'hD: g = 8'hA1;
            4'hE: g = 8'h86;
            default: g = 8'h8E;
        endcase
        return g;
    endfunction

    assign scan_wrap = (scan_q == SCAN_MAX);
    assign idx_nxt   = scan_wrap ? idx_q + 3'd1 : idx_q;
    assign dig_nxt   = wr_dig ? Bus_wdata : dig_q;

    // dig_en/seg are built from the same next-state values that load idx/DIG,
    // so the enable and its glyph always change on the same edge.
    always_ff @(posedge cpu_clk or negedge cpu_rst) begin
        if (!cpu_rst) begin
            scan_q   <= '0;
            idx_q    <= '0;
            dig_q    <= '0;
            dig_en_q <= 8'hFE;
            seg_q    <= 8'hC0;
        end else begin
            scan_q   <= scan_wrap ? '0 : scan_q + 1'b1;
            idx_q    <= idx_nxt;
            dig_q    <= dig_nxt;
            dig_en_q <= ~(8'b1 << idx_nxt);
            seg_q    <= glyph(dig_nxt[idx_nxt*4 +: 4]);
        end
    end

    assign dig_en = dig_en_q;
    assign seg    = seg_q;

    // ------------------------------------------------------------------
    // Read mux
    // ------------------------------------------------------------------
    always_comb begin
        Bus_rdata = dram_rdata;
        if (sel_dig)   Bus_rdata = dig_q;
        if (sel_timer) Bus_rdata = timer_val;
        if (sel_led)   Bus_rdata = {8'h0, led_q};
        if (sel_sw)    Bus_rdata = {8'h0, sw_sync};
    end

endmodule

// File: tb/tb_bridge_io.sv
module tb_bridge_io;

    logic        cpu_clk = 1'b0;
    logic        cpu_rst;
    logic [31:0] Bus_addr;
    logic        Bus_we;
    logic [31:0] Bus_wdata;
    logic [31:0] Bus_rdata;
    logic [13:0] dram_addr;
    logic        dram_we;
    logic [31:0] dram_wdata;
    logic [31:0] dram_rdata;
    logic [23:0] sw;
    logic [23:0] led;
    logic [7:0]  dig_en;
    logic [7:0]  seg;

    bridge_io #(.SCAN_DIV(4), .TIMER_DIV(2)) dut (
        .cpu_clk    (cpu_clk),
        .cpu_rst    (cpu_rst),
        .Bus_addr   (Bus_addr),
        .Bus_we     (Bus_we),
        .Bus_wdata  (Bus_wdata),
        .Bus_rdata  (Bus_rdata),
        .dram_addr  (dram_addr),
        .dram_we    (dram_we),
        .dram_wdata (dram_wdata),
        .dram_rdata (dram_rdata),
        .sw         (sw),
        .led        (led),
        .dig_en     (dig_en),
        .seg        (seg)
    );

    always #5 cpu_clk = ~cpu_clk;

    localparam logic [31:0] A_DIG   = 32'hFFFF_F000;
    localparam logic [31:0] A_TIMER = 32'hFFFF_F020;
    localparam logic [31:0] A_LED   = 32'hFFFF_F060;
    localparam logic [31:0] A_SW    = 32'hFFFF_F070;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge cpu_clk);
        #1;
    endtask

    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [31:0] wdata;
        logic [31:0] drd;
        logic [31:0] exp_rdata;  // combinational, before the edge
        logic        exp_dwe;
        logic [23:0] exp_led;    // after the edge
    } vec_t;

    vec_t vecs[8];

    // Free-running watchdog: every wait below is a fixed cycle count, this is a backstop only.
    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{32'h0000_0010, 1'b1, 32'h1234_5678, 32'h0000_CAFE, 32'h0000_CAFE, 1'b1, 24'h0};
        vecs[1] = '{32'h0000_0010, 1'b0, 32'h0000_0000, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0, 24'h0};
        vecs[2] = '{A_LED,         1'b1, 32'hFFAB_CDEF, 32'h1111_1111, 32'h0000_0000, 1'b0, 24'hABCDEF};
        vecs[3] = '{A_LED,         1'b0, 32'h0000_0000, 32'h1111_1111, 32'h00AB_CDEF, 1'b0, 24'hABCDEF};
        vecs[4] = '{A_SW,          1'b1, 32'h0000_0123, 32'h2222_2222, 32'h0000_0000, 1'b0, 24'hABCDEF};
        vecs[5] = '{A_DIG,         1'b1, 32'h0000_00A1, 32'h3333_3333, 32'h0000_0000, 1'b0, 24'hABCDEF};
        vecs[6] = '{A_DIG,         1'b0, 32'h0000_0000, 32'h3333_3333, 32'h0000_00A1, 1'b0, 24'hABCDEF};
        vecs[7] = '{32'hFFFF_F004, 1'b1, 32'h0BAD_F00D, 32'h0000_0055, 32'h0000_0055, 1'b1, 24'hABCDEF};

        cpu_rst    = 1'b0;
        Bus_addr   = A_DIG;
        Bus_we     = 1'b0;
        Bus_wdata  = '0;
        dram_rdata = '0;
        sw         = '0;

        // ---- reset state ----
        #12;
        check("rst_led",    32'(led),    32'h0);
        check("rst_dig_en", 32'(dig_en), 32'hFE);
        check("rst_seg",    32'(seg),    32'hC0);
        check("rst_dig_rd", Bus_rdata,   32'h0);
        Bus_addr = A_TIMER;
        #1;
        check("rst_timer_rd", Bus_rdata, 32'h0);

        @(negedge cpu_clk);
        cpu_rst = 1'b1;

        // ---- decode / read-write table ----
        for (int i = 0; i < 8; i++) begin
            Bus_addr   = vecs[i].addr;
            Bus_we     = vecs[i].we;
            Bus_wdata  = vecs[i].wdata;
            dram_rdata = vecs[i].drd;
            #1;
            check($sformatf("vec%0d_rdata", i), Bus_rdata, vecs[i].exp_rdata);
            check($sformatf("vec%0d_dram_we", i), 32'(dram_we), 32'(vecs[i].exp_dwe));
            check($sformatf("vec%0d_dram_addr", i), 32'(dram_addr), 32'(vecs[i].addr[15:2]));
            check($sformatf("vec%0d_dram_wdata", i), dram_wdata, vecs[i].wdata);
            step(1);
            check($sformatf("vec%0d_led", i), 32'(led), 32'(vecs[i].exp_led));
        end
        Bus_we = 1'b0;

        // ---- switch synchronizer: two edges of latency ----
        Bus_addr = A_SW;
        sw       = 24'h00F00F;
        #1;
        check("sw_edge0", Bus_rdata, 32'h0);
        step(1);
        check("sw_edge1", Bus_rdata, 32'h0);
        step(1);
        check("sw_edge2", Bus_rdata, 32'h0000_F00F);
        step(1);
        check("sw_edge3", Bus_rdata, 32'h0000_F00F);

        // ---- asynchronous reset mid-operation ----
        step(2);
        cpu_rst = 1'b0;
        #1;
        check("arst_led",    32'(led),    32'h0);
        check("arst_dig_en", 32'(dig_en), 32'hFE);
        check("arst_seg",    32'(seg),    32'hC0);
        check("arst_sw_rd",  Bus_rdata,   32'h0);
        Bus_addr = A_TIMER;
        #1;
        check("arst_timer_rd", Bus_rdata, 32'h0);

        // ---- display scan from a fresh reset, SCAN_DIV=4 ----
        @(negedge cpu_clk);
        cpu_rst   = 1'b1;
        Bus_addr  = A_DIG;
        Bus_we    = 1'b1;
        Bus_wdata = 32'h0123_45F8;
        step(1);                         // edge 1 after release
        Bus_we = 1'b0;
        check("disp_e1_en",  32'(dig_en), 32'hFE);
        check("disp_e1_seg", 32'(seg),    32'h80);
        check("disp_dig_rd", Bus_rdata,   32'h0123_45F8);
        step(2);                         // edge 3
        check("disp_e3_en",  32'(dig_en), 32'hFE);
        step(1);                         // edge 4
        check("disp_e4_en",  32'(dig_en), 32'hFD);
        check("disp_e4_seg", 32'(seg),    32'h8E);
        step(4);                         // edge 8
        check("disp_e8_en",  32'(dig_en), 32'hFB);
        check("disp_e8_seg", 32'(seg),    32'h92);
        step(20);                        // edge 28
        check("disp_e28_en",  32'(dig_en), 32'h7F);
        check("disp_e28_seg", 32'(seg),    32'hC0);
        step(4);                         // edge 32
        check("disp_e32_en",  32'(dig_en), 32'hFE);
        check("disp_e32_seg", 32'(seg),    32'h80);

        // A DIG write must not disturb the scan position.
        Bus_we    = 1'b1;
        Bus_wdata = 32'h0000_00A0;
        step(1);                         // edge 33
        Bus_we = 1'b0;
        check("digwr_e33_en",  32'(dig_en), 32'hFE);
        check("digwr_e33_seg", 32'(seg),    32'hC0);
        step(3);                         // edge 36
        check("digwr_e36_en",  32'(dig_en), 32'hFD);
        check("digwr_e36_seg", 32'(seg),    32'h88);

        // ---- timer ----
        Bus_addr  = A_TIMER;
        Bus_we    = 1'b1;
        Bus_wdata = 32'hFFFF_FFFF;
        #1;
        check("tmr_wr_dram_we", 32'(dram_we), 32'h0);
        step(1);
        Bus_we = 1'b0;
`ifdef BRIDGE_TIMER_EN
        check("tmr_load",   Bus_rdata, 32'hFFFF_FFFF);
        step(1);
        check("tmr_hold",   Bus_rdata, 32'hFFFF_FFFF);
        step(1);
        check("tmr_wrap",   Bus_rdata, 32'h0);
        step(1);
        check("tmr_mid",    Bus_rdata, 32'h0);
        // Next edge would tick; a write on that edge must win.
        Bus_we    = 1'b1;
        Bus_wdata = 32'h0000_0100;
        step(1);
        Bus_we = 1'b0;
        check("tmr_wr_wins", Bus_rdata, 32'h0000_0100);
        step(1);
        check("tmr_pre_restart", Bus_rdata, 32'h0000_0100);
        step(1);
        check("tmr_tick", Bus_rdata, 32'h0000_0101);
`else
        check("tmr_absent_rd", Bus_rdata, 32'h0);
        step(3);
        check("tmr_absent_rd2", Bus_rdata, 32'h0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
